// File: rtl/nn_pkg.sv
// Shared parameters, state encoding and trained weight tables for the
// time-multiplexed 6-7-3 move classifier.
package nn_pkg;

    localparam int NUM_IN  = 6;
    localparam int NUM_HID = 7;
    localparam int NUM_OUT = 3;
    localparam int W_W     = 12;
    localparam int HID_W   = 12;
    localparam int SCORE_W = 26;
    localparam int MUL_A_W = HID_W + 1;
    localparam int OACC_W  = 30;

    localparam logic [2:0] H_LAST_TERM = 3'd6;
    localparam logic [2:0] O_LAST_TERM = 3'd7;
    localparam logic [2:0] H_LAST_NODE = 3'd6;
    localparam logic [2:0] O_LAST_NODE = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HID  = 2'd1,
        OUT  = 2'd2,
        ARG  = 2'd3
    } state_e;

    // Row per hidden node: weights for in1..in6, then bias.
    localparam logic signed [W_W-1:0] W_H [NUM_HID][NUM_IN+1] = '{
        '{ 12'sd120, -12'sd85,  12'sd60,  -12'sd40,  12'sd33,  -12'sd150,  12'sd89},
        '{-12'sd200,  12'sd140, 12'sd75,  -12'sd60,  12'sd210, -12'sd30,  -12'sd20},
        '{ 12'sd55,   12'sd180,-12'sd120,  12'sd95, -12'sd70,   12'sd130, -12'sd45},
        '{-12'sd90,  -12'sd110, 12'sd200,  12'sd160,-12'sd40,   12'sd75,  -12'sd10},
        '{ 12'sd300, -12'sd250,-12'sd30,   12'sd140, 12'sd90,  -12'sd60,   12'sd40},
        '{ 12'sd70,   12'sd65, -12'sd180, -12'sd220, 12'sd150,  12'sd115, -12'sd5 },
        '{-12'sd140,  12'sd230, 12'sd110, -12'sd75, -12'sd95,   12'sd185, -12'sd30}
    };

    // Row per output node: weights for hidden0..hidden6, then bias.
    localparam logic signed [W_W-1:0] W_O [NUM_OUT][NUM_HID+1] = '{
        '{12'sd314, -12'sd199, -12'sd82,  12'sd465, -12'sd393,  12'sd280, -12'sd101,  12'sd0 },
        '{12'sd791,  12'sd317, -12'sd438, 12'sd365,  12'sd376, -12'sd790, -12'sd137,  12'sd0 },
        '{12'sd441,  12'sd221,  12'sd36,  12'sd366, -12'sd301,  12'sd420,  12'sd667, -12'sd13}
    };

    function automatic logic signed [W_W-1:0] w_hid(input logic [2:0] n, input logic [2:0] t);
        return W_H[int'(n)][int'(t)];
    endfunction

    function automatic logic signed [W_W-1:0] w_out(input logic [1:0] n, input logic [2:0] t);
        return W_O[int'(n)][int'(t)];
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Shared signed multiply-accumulate with clear; exposes the running sum
// including the current product, already ReLU'd and saturated.
module nn_mac_unit
    import nn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      en,
    input  logic signed [MUL_A_W-1:0] a,
    input  logic signed [W_W-1:0]     b,
    output logic [HID_W-1:0]          hid_sat,
    output logic [SCORE_W-1:0]        score_sat
);

    localparam int PROD_W = MUL_A_W + W_W;

    logic signed [OACC_W-1:0] acc_q, acc_d, sum;
    logic signed [PROD_W-1:0] prod;

    // One 30-bit accumulator serves both phases; hidden sums fit in its low 15 bits.
    always_comb begin
        prod = a * b;
        sum  = acc_q + {{(OACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = sum;
    end

    always_comb begin
        hid_sat   = sum[HID_W-1:0];
        score_sat = sum[SCORE_W-1:0];
        if (sum[OACC_W-1]) begin
            hid_sat   = '0;
            score_sat = '0;
        end else begin
            if (|sum[OACC_W-2:HID_W])
                hid_sat = '1;
            if (|sum[OACC_W-2:SCORE_W])
                score_sat = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/nn_infer_sequencer.sv
// Sequences one shared MAC over the 7 hidden and 3 output nodes of the move
// classifier, then publishes argmax move, scores and hidden activations.
module nn_infer_sequencer
    import nn_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_IN-1:0]          in_vec,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 move,
    output logic [NUM_OUT*SCORE_W-1:0] score,
    output logic [NUM_HID*HID_W-1:0]   hid_act
);

    state_e                          state_q, state_d;
    logic [2:0]                      node_q, node_d;
    logic [2:0]                      term_q, term_d;
    logic [NUM_IN-1:0]               in_q, in_d;
    logic [NUM_HID-1:0][HID_W-1:0]   hid_w_q, hid_w_d;
    logic [NUM_OUT-1:0][SCORE_W-1:0] score_w_q, score_w_d;
    logic [NUM_HID-1:0][HID_W-1:0]   hid_act_q, hid_act_d;
    logic [NUM_OUT-1:0][SCORE_W-1:0] score_q, score_d;
    logic [1:0]                      move_q, move_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic                            mac_clr, mac_en;
    logic signed [MUL_A_W-1:0]       mac_a;
    logic signed [W_W-1:0]           mac_b;
    logic [HID_W-1:0]                mac_hid;
    logic [SCORE_W-1:0]              mac_score;

    nn_mac_unit u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (mac_clr),
        .en        (mac_en),
        .a         (mac_a),
        .b         (mac_b),
        .hid_sat   (mac_hid),
        .score_sat (mac_score)
    );

    always_comb begin
        state_d   = state_q;
        node_d    = node_q;
        term_d    = term_q;
        in_d      = in_q;
        hid_w_d   = hid_w_q;
        score_w_d = score_w_q;
        hid_act_d = hid_act_q;
        score_d   = score_q;
        move_d    = move_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        mac_a     = '0;
        mac_b     = '0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    in_d    = in_vec;
                    node_d  = '0;
                    term_d  = '0;
                    mac_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = HID;
                end
            end
            HID: begin
                // Binary features gate the weight through a 0/1 multiplicand.
                mac_en = 1'b1;
                mac_a  = (term_q == H_LAST_TERM) ? MUL_A_W'(1) : MUL_A_W'(in_q[term_q]);
                mac_b  = w_hid(node_q, term_q);
                term_d = term_q + 3'd1;
                if (term_q == H_LAST_TERM) begin
                    hid_w_d[node_q] = mac_hid;
                    mac_clr = 1'b1;
                    term_d  = '0;
                    node_d  = node_q + 3'd1;
                    if (node_q == H_LAST_NODE) begin
                        node_d  = '0;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                mac_en = 1'b1;
                mac_a  = (term_q == O_LAST_TERM) ? MUL_A_W'(1) : MUL_A_W'(hid_w_q[term_q]);
                mac_b  = w_out(node_q[1:0], term_q);
                term_d = term_q + 3'd1;
                if (term_q == O_LAST_TERM) begin
                    score_w_d[node_q[1:0]] = mac_score;
                    mac_clr = 1'b1;
                    term_d  = '0;
                    node_d  = node_q + 3'd1;
                    if (node_q == O_LAST_NODE) begin
                        node_d  = '0;
                        state_d = ARG;
                    end
                end
            end
            ARG: begin
                // Strict compares push ties toward the higher index.
                if (score_w_q[0] > score_w_q[1])
                    move_d = (score_w_q[0] > score_w_q[2]) ? 2'd0 : 2'd2;
                else
                    move_d = (score_w_q[1] > score_w_q[2]) ? 2'd1 : 2'd2;
                score_d   = score_w_q;
                hid_act_d = hid_w_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            move_d    = move_q;
            score_d   = score_q;
            hid_act_d = hid_act_q;
            in_d      = in_q;
            mac_clr   = 1'b1;
            mac_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            node_q    <= '0;
            term_q    <= '0;
            in_q      <= '0;
            hid_w_q   <= '0;
            score_w_q <= '0;
            hid_act_q <= '0;
            score_q   <= '0;
            move_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            node_q    <= node_d;
            term_q    <= term_d;
            in_q      <= in_d;
            hid_w_q   <= hid_w_d;
            score_w_q <= score_w_d;
            hid_act_q <= hid_act_d;
            score_q   <= score_d;
            move_q    <= move_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign move    = move_q;
    assign score   = score_q;
    assign hid_act = hid_act_q;

endmodule
